// File: rtl/servo_slew_pwm_pkg.sv
// Shared servo constants, FSM encoding and angle helpers.
// Latency: n/a (package of types, constants and pure functions).
// Backpressure: n/a.
package servo_slew_pwm_pkg;

  // Mechanical end stop of the servo, in degrees.
  localparam int ANGLE_MAX = 180;

  // Default timebase shared by all four servo channels (50 MHz core clock).
  localparam int DEF_TICK_DIV      = 50;     // clk cycles per 1 us tick
  localparam int DEF_FRAME_TICKS   = 20000;  // 20 ms frame
  localparam int DEF_MIN_TICKS     = 1000;   // 1.0 ms pulse at 0 degrees
  localparam int DEF_TICKS_PER_DEG = 5;      // +5 us per degree
  localparam int DEF_STEP_MAX      = 2;      // degrees per frame

  typedef logic [7:0] angle_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Saturate a requested angle at the mechanical end stop.
  function automatic angle_t clamp_angle(input angle_t a);
    return (int'(a) > ANGLE_MAX) ? angle_t'(ANGLE_MAX) : a;
  endfunction

  // Move cur toward tgt by at most step_max degrees.
  function automatic angle_t slew_step(input angle_t cur, input angle_t tgt, input int step_max);
    int diff;
    int step;
    if (tgt >= cur) diff = int'(tgt) - int'(cur);
    else            diff = int'(cur) - int'(tgt);
    step = (diff > step_max) ? step_max : diff;
    if (tgt >= cur) return angle_t'(int'(cur) + step);
    else            return angle_t'(int'(cur) - step);
  endfunction

endpackage

// File: rtl/servo_slew_pwm_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clk cycles while en is high.
// Latency: first tick TICK_DIV cycles after en rises; counter held at 0 while en is low.
// Backpressure: none.
// Ports: clk, reset (sync, active high), en (run), tick (one-cycle strobe, combinational from count).
module tick_gen
  import servo_slew_pwm_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Holding the count at 0 while disabled makes the first tick after
  // leaving IDLE land a full TICK_DIV cycles later.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_slew_pwm.sv
// Servo PWM channel: frame generator with per-frame slew-limited angle.
// Latency: target registers 1 clk after angle_valid; applied at the next frame start.
// Backpressure: none; every angle_valid strobe is accepted.
// Ports: clk, reset (sync, active high), angle_in/angle_valid (target load), enable (frame run),
//        pwm (pulse), cur_angle (driven angle), busy (cur != target), frame_start (1-cycle strobe).
module servo_slew_pwm
  import servo_slew_pwm_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int FRAME_TICKS   = DEF_FRAME_TICKS,
  parameter int MIN_TICKS     = DEF_MIN_TICKS,
  parameter int TICKS_PER_DEG = DEF_TICKS_PER_DEG,
  parameter int STEP_MAX      = DEF_STEP_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] angle_in,
  input  logic       angle_valid,
  input  logic       enable,
  output logic       pwm,
  output logic [7:0] cur_angle,
  output logic       busy,
  output logic       frame_start
);

  // Tick counter wide enough for the frame, never narrower than 16 bits.
  localparam int TW_RAW = $clog2(FRAME_TICKS + 1);
  localparam int TW     = (TW_RAW > 16) ? TW_RAW : 16;
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TICKS);

  // The longest pulse must fit inside the frame, and a zero-width pulse
  // would never match the tick count.
  if (MIN_TICKS + ANGLE_MAX * TICKS_PER_DEG >= FRAME_TICKS) begin : g_bad_frame
    $error("servo_slew_pwm: MIN_TICKS + 180*TICKS_PER_DEG must be below FRAME_TICKS");
  end
  if (MIN_TICKS < 1 || TICK_DIV < 1 || STEP_MAX < 1) begin : g_bad_param
    $error("servo_slew_pwm: MIN_TICKS, TICK_DIV and STEP_MAX must be at least 1");
  end

  state_e        state_q;
  angle_t        target_q;
  angle_t        cur_q;
  logic [TW-1:0] width_q;
  logic [TW-1:0] tcnt_q;
  logic          pwm_q;
  logic          fs_q;

  logic          tick;
  angle_t        cur_d;
  logic [TW-1:0] width_d;
  logic [TW-1:0] tcnt_inc;
  logic          frame_end;
  logic          start_frame;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != ST_IDLE),
    .tick  (tick)
  );

  // Slew and width are computed from the pre-edge target, so a strobe landing
  // on the frame-start edge is stored but only steers the following frame.
  always_comb begin
    cur_d       = slew_step(cur_q, target_q, STEP_MAX);
    width_d     = TW'(MIN_TICKS) + TW'(cur_d) * TW'(TICKS_PER_DEG);
    tcnt_inc    = tcnt_q + 1'b1;
    frame_end   = (state_q == ST_LOW) && tick && (tcnt_inc == FRAME_LAST);
    start_frame = enable && ((state_q == ST_IDLE) || frame_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cur_q    <= '0;
      width_q  <= '0;
      tcnt_q   <= '0;
      pwm_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (angle_valid) target_q <= clamp_angle(angle_in);

      if (start_frame) begin
        state_q <= ST_HIGH;
        pwm_q   <= 1'b1;
        fs_q    <= 1'b1;
        cur_q   <= cur_d;
        width_q <= width_d;
        tcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_HIGH: begin
            if (tick) begin
              tcnt_q <= tcnt_inc;
              if (tcnt_inc == width_q) begin
                state_q <= ST_LOW;
                pwm_q   <= 1'b0;
              end
            end
          end
          ST_LOW: begin
            // enable is only consulted at the frame boundary, so a frame
            // in flight always finishes whole.
            if (frame_end) begin
              state_q <= ST_IDLE;
              tcnt_q  <= '0;
            end else if (tick) begin
              tcnt_q <= tcnt_inc;
            end
          end
          ST_IDLE: begin
            pwm_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            pwm_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pwm         = pwm_q;
  assign cur_angle   = cur_q;
  assign frame_start = fs_q;
  assign busy        = (cur_q != target_q);

endmodule

// File: tb/tb_servo_slew_pwm.sv
// Directed bench for servo_slew_pwm: two channels share one clock.
// u_fast: TICK_DIV=1, unlimited slew; u_slew: TICK_DIV=2, STEP_MAX=2.
// Outputs sampled and inputs driven on the falling edge.
module tb_servo_slew_pwm;
  import servo_slew_pwm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f, vld_f, en_f, pwm_f, busy_f, fs_f;
  logic [7:0] ang_f, cur_f;
  logic       rst_s, vld_s, en_s, pwm_s, busy_s, fs_s;
  logic [7:0] ang_s, cur_s;

  servo_slew_pwm #(
    .TICK_DIV(1), .FRAME_TICKS(250), .MIN_TICKS(10), .TICKS_PER_DEG(1), .STEP_MAX(200)
  ) u_fast (
    .clk(clk), .reset(rst_f), .angle_in(ang_f), .angle_valid(vld_f), .enable(en_f),
    .pwm(pwm_f), .cur_angle(cur_f), .busy(busy_f), .frame_start(fs_f)
  );

  servo_slew_pwm #(
    .TICK_DIV(2), .FRAME_TICKS(250), .MIN_TICKS(10), .TICKS_PER_DEG(1), .STEP_MAX(2)
  ) u_slew (
    .clk(clk), .reset(rst_s), .angle_in(ang_s), .angle_valid(vld_s), .enable(en_s),
    .pwm(pwm_s), .cur_angle(cur_s), .busy(busy_s), .frame_start(fs_s)
  );

  logic sel;  // 0: u_fast, 1: u_slew
  logic pwm_m, fs_m;
  assign pwm_m = sel ? pwm_s : pwm_f;
  assign fs_m  = sel ? fs_s  : fs_f;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_vld(input logic [7:0] a, input logic v);
    if (sel) begin ang_s = a; vld_s = v; end
    else     begin ang_f = a; vld_f = v; end
  endtask

  task automatic drive_en(input logic e);
    if (sel) en_s = e;
    else     en_f = e;
  endtask

  task automatic load_angle(input logic [7:0] a);
    drive_vld(a, 1'b1);
    @(negedge clk);
    drive_vld(8'd0, 1'b0);
  endtask

  // Advance falling edges until frame_start is seen, bounded.
  task automatic wait_fs(input string tag, input int limit);
    int found;
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (fs_m) begin found = 1; break; end
    end
    chk(tag, found, 1);
  endtask

  // Called on the falling edge where frame_start is high. Counts pwm high/low
  // cycles until the next frame_start (or limit). Optionally strobes a new
  // angle or drops enable at a given cycle index of the frame.
  task automatic run_frame(input int limit, input int inj_at, input logic [7:0] inj_ang,
                           input int drop_at, output int hi, output int lo, output int seen);
    hi = 0; lo = 0; seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (pwm_m) hi++; else lo++;
      if (i == inj_at)  drive_vld(inj_ang, 1'b1);
      if (i == drop_at) drive_en(1'b0);
      @(negedge clk);
      drive_vld(8'd0, 1'b0);
      if (fs_m) begin seen = 1; break; end
    end
  endtask

  int hi, lo, seen;

  initial begin
    sel = 1'b0;
    rst_f = 1'b1; rst_s = 1'b1;
    ang_f = '0; vld_f = 1'b0; en_f = 1'b0;
    ang_s = '0; vld_s = 1'b0; en_s = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pwm",   pwm_f,  0);
    chk("rst_cur",   cur_f,  0);
    chk("rst_busy",  busy_f, 0);
    chk("rst_fs",    fs_f,   0);
    chk("rst_cur_s", cur_s,  0);
    rst_f = 1'b0; rst_s = 1'b0;
    @(negedge clk);

    // 90 degrees loaded before the first frame: 100 high / 150 low
    load_angle(8'd90);
    chk("busy_loaded", busy_f, 1);
    chk("idle_pwm",    pwm_f,  0);
    en_f = 1'b1;
    wait_fs("fs_first", 20);
    chk("cur_90",  cur_f,  90);
    chk("busy_90", busy_f, 0);
    chk("pwm_hi0", pwm_f,  1);
    run_frame(1000, -1, 8'd0, -1, hi, lo, seen);
    chk("f1_hi", hi, 100); chk("f1_lo", lo, 150); chk("f1_fs", seen, 1);

    // Strobe 200 at cycle 50 of the pulse: current pulse unchanged
    run_frame(1000, 50, 8'd200, -1, hi, lo, seen);
    chk("mid_hi", hi, 100); chk("mid_lo", lo, 150); chk("mid_fs", seen, 1);
    chk("cur_180",   cur_f, 180);
    chk("tgt_clamp", u_fast.target_q, 180);
    chk("busy_180",  busy_f, 0);
    run_frame(1000, -1, 8'd0, -1, hi, lo, seen);
    chk("f180_hi", hi, 190); chk("f180_lo", lo, 60); chk("f180_fs", seen, 1);

    // Enable dropped at tick 30: full pulse, then IDLE with no frame_start
    run_frame(600, -1, 8'd0, 30, hi, lo, seen);
    chk("drop_hi", hi, 190); chk("drop_lo", lo, 410); chk("drop_nofs", seen, 0);
    chk("drop_idle", int'(u_fast.state_q), int'(ST_IDLE));

    // Reset 40 ticks into the pulse
    en_f = 1'b1;
    wait_fs("fs_rearm", 20);
    chk("rearm_cur", cur_f, 180);
    repeat (40) @(negedge clk);
    chk("pre_rst_pwm", pwm_f, 1);
    rst_f = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm",  pwm_f,  0);
    chk("mid_rst_cur",  cur_f,  0);
    chk("mid_rst_busy", busy_f, 0);
    rst_f = 1'b0;
    wait_fs("fs_post_rst", 5);
    chk("post_rst_cur", cur_f, 0);
    run_frame(1000, -1, 8'd0, -1, hi, lo, seen);
    chk("post_rst_hi", hi, 10); chk("post_rst_lo", lo, 240);
    en_f = 1'b0;

    // Slew channel: 0 -> 10 in 2-degree steps, pulses 12..20 ticks (x2 clk)
    sel = 1'b1;
    load_angle(8'd10);
    en_s = 1'b1;
    wait_fs("fs_slew", 20);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("slew_cur%0d", k),  cur_s,  2 * k);
      chk($sformatf("slew_busy%0d", k), busy_s, (k < 5) ? 1 : 0);
      run_frame(1200, (k == 5) ? 5 : -1, 8'd20, -1, hi, lo, seen);
      chk($sformatf("slew_hi%0d", k), hi, 2 * (10 + 2 * k));
      chk($sformatf("slew_lo%0d", k), lo, 500 - 2 * (10 + 2 * k));
    end

    // Strobe on the frame-start edge: slew uses the old target (20)
    chk("tgt20_cur", cur_s, 12);
    run_frame(1200, 499, 8'd0, -1, hi, lo, seen);
    chk("tgt20_hi", hi, 44);
    chk("same_edge_cur",  cur_s,  14);
    chk("same_edge_busy", busy_s, 1);
    run_frame(1200, -1, 8'd0, -1, hi, lo, seen);
    chk("same_edge_hi", hi, 48);
    chk("back_cur", cur_s, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
